// File: rtl/wb_regfile.sv
// MIPS write-back stage: write-back mux plus 32 x 32 register file with hardwired $0.
// Optional same-cycle write-through bypass on the read ports: WB_REGFILE_BYPASS_EN.
module wb_regfile #(
    parameter int unsigned DATA_W = 32,
    parameter int unsigned NREG   = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [1:0]        wb_in,
    input  logic [DATA_W-1:0] add_in,
    input  logic [DATA_W-1:0] dm_in,
    input  logic [4:0]        rd_in,
    input  logic [4:0]        ra1,
    input  logic [4:0]        ra2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2,
    output logic [DATA_W-1:0] wb_data,
    output logic              wb_we
);

    localparam int unsigned AW = 5;

    // Register $0 has no storage; entries 1..NREG-1 only.
    logic [DATA_W-1:0] regs_q [1:NREG-1];

    // Write-back source select and effective write enable.
    always_comb begin
        wb_data = wb_in[0] ? dm_in : add_in;
        wb_we   = wb_in[1] & (rd_in != AW'(0)) & ~rst;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 1; i < int'(NREG); i++) begin
                regs_q[i] <= '0;
            end
        end else if (wb_we) begin
            regs_q[rd_in] <= wb_data;
        end
    end

    // Combinational read ports; address 0 and reset force zero.
    always_comb begin
        rdata1 = '0;
        rdata2 = '0;
        if (!rst) begin
            if (ra1 != AW'(0)) begin
                rdata1 = regs_q[ra1];
            end
            if (ra2 != AW'(0)) begin
                rdata2 = regs_q[ra2];
            end
`ifdef WB_REGFILE_BYPASS_EN
            // wb_we already excludes rd_in == 0, so $0 is never bypassed.
            if (wb_we && (ra1 == rd_in)) begin
                rdata1 = wb_data;
            end
            if (wb_we && (ra2 == rd_in)) begin
                rdata2 = wb_data;
            end
`else
`endif
        end
    end

endmodule

// File: tb/tb_wb_regfile.sv
// Directed self-checking bench for wb_regfile (default and bypass builds).
module tb_wb_regfile;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  wb_in;
    logic [31:0] add_in;
    logic [31:0] dm_in;
    logic [4:0]  rd_in;
    logic [4:0]  ra1;
    logic [4:0]  ra2;
    logic [31:0] rdata1;
    logic [31:0] rdata2;
    logic [31:0] wb_data;
    logic        wb_we;

    int checks   = 0;
    int failures = 0;

    wb_regfile #(.DATA_W(32), .NREG(32)) dut (
        .clk     (clk),
        .rst     (rst),
        .wb_in   (wb_in),
        .add_in  (add_in),
        .dm_in   (dm_in),
        .rd_in   (rd_in),
        .ra1     (ra1),
        .ra2     (ra2),
        .rdata1  (rdata1),
        .rdata2  (rdata2),
        .wb_data (wb_data),
        .wb_we   (wb_we)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    // Advance one rising edge; inputs change and outputs settle 1 time unit later.
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic write_reg(input logic [4:0] rd, input logic [31:0] val);
        wb_in  = 2'b10;
        rd_in  = rd;
        add_in = val;
        step();
        wb_in  = 2'b00;
        #1;
    endtask

    logic [31:0] pre_exp;

    initial begin
        rst    = 1'b1;
        wb_in  = 2'b10;
        rd_in  = 5'd5;
        add_in = 32'hDEADBEEF;
        dm_in  = 32'h0;
        ra1    = 5'd5;
        ra2    = 5'd0;
        step();
        check("rst_wb_we", 32'(wb_we), 32'h0);
        check("rst_rdata1", rdata1, 32'h0);
        check("rst_wb_data_mux", wb_data, 32'hDEADBEEF);
        step();
        check("rst_wb_we_2", 32'(wb_we), 32'h0);

        // Release reset; the write held during reset must have been dropped.
        rst   = 1'b0;
        wb_in = 2'b00;
        #1;
        check("post_rst_r5", rdata1, 32'h0);
        for (int a = 0; a < 32; a++) begin
            ra1 = 5'(a);
            ra2 = 5'(31 - a);
            #1;
            check($sformatf("zero_p1_r%0d", a), rdata1, 32'h0);
            check($sformatf("zero_p2_r%0d", 31 - a), rdata2, 32'h0);
        end

        // ALU write-back
        wb_in  = 2'b10;
        rd_in  = 5'd8;
        add_in = 32'h00000123;
        dm_in  = 32'hFFFFFFFF;
        ra1    = 5'd8;
        #1;
        check("alu_wb_data", wb_data, 32'h00000123);
        check("alu_wb_we", 32'(wb_we), 32'h1);
        step();
        wb_in = 2'b00;
        #1;
        check("alu_r8", rdata1, 32'h00000123);

        // Load write-back, then mem_to_reg without reg_write
        wb_in = 2'b11;
        rd_in = 5'd9;
        dm_in = 32'hCAFEF00D;
        ra2   = 5'd9;
        #1;
        check("ld_wb_data", wb_data, 32'hCAFEF00D);
        step();
        wb_in = 2'b01;
        dm_in = 32'h12345678;
        #1;
        check("ld_r9", rdata2, 32'hCAFEF00D);
        check("nowr_wb_we", 32'(wb_we), 32'h0);
        check("nowr_wb_data", wb_data, 32'h12345678);
        step();
        check("nowr_r9", rdata2, 32'hCAFEF00D);

        // $0 protection
        wb_in  = 2'b10;
        rd_in  = 5'd0;
        add_in = 32'h00000055;
        ra1    = 5'd0;
        #1;
        check("r0_wb_we", 32'(wb_we), 32'h0);
        check("r0_pre", rdata1, 32'h0);
        step();
        check("r0_post", rdata1, 32'h0);
        wb_in = 2'b00;

        // Same-cycle read of the register being written
        write_reg(5'd4, 32'h00000011);
        ra1    = 5'd4;
        ra2    = 5'd4;
        wb_in  = 2'b10;
        rd_in  = 5'd4;
        add_in = 32'h00000022;
        #1;
`ifdef WB_REGFILE_BYPASS_EN
        pre_exp = 32'h00000022;
`else
        pre_exp = 32'h00000011;
`endif
        check("rw_pre_p1", rdata1, pre_exp);
        check("rw_pre_p2", rdata2, pre_exp);
        step();
        wb_in = 2'b00;
        #1;
        check("rw_post_p1", rdata1, 32'h00000022);
        check("rw_post_p2", rdata2, 32'h00000022);

        // Back-to-back writes to r7 while reading r6
        write_reg(5'd6, 32'h00000066);
        ra1 = 5'd6;
        ra2 = 5'd7;
        for (int k = 1; k <= 3; k++) begin
            wb_in  = 2'b10;
            rd_in  = 5'd7;
            add_in = 32'(k);
            #1;
            check($sformatf("b2b_r6_%0d", k), rdata1, 32'h00000066);
            step();
        end
        wb_in = 2'b00;
        #1;
        check("b2b_r7", rdata2, 32'h00000003);
        check("b2b_r6", rdata1, 32'h00000066);

        // Reset mid-pipeline: presented write lost, storage cleared
        rst    = 1'b1;
        wb_in  = 2'b10;
        rd_in  = 5'd10;
        add_in = 32'h0000AAAA;
        ra1    = 5'd8;
        ra2    = 5'd10;
        #1;
        check("mid_rst_forced_r8", rdata1, 32'h0);
        check("mid_rst_wb_we", 32'(wb_we), 32'h0);
        step();
        rst   = 1'b0;
        wb_in = 2'b00;
        #1;
        check("mid_rst_r8_cleared", rdata1, 32'h0);
        check("mid_rst_r10_dropped", rdata2, 32'h0);
        ra1 = 5'd7;
        #1;
        check("mid_rst_r7_cleared", rdata1, 32'h0);

        // First write after reset is accepted
        ra1 = 5'd11;
        write_reg(5'd11, 32'h00000077);
        check("post_rst_first_wr", rdata1, 32'h00000077);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
